// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single data memory: core (C) and debug/DMA (D).
// Latches the winning request, checks alignment, runs one access, returns a one-cycle ack.
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [DM_ADDRESS-1:0] c_addr,
    input  logic [DATA_W-1:0]     c_wdata,
    input  logic [2:0]            c_funct3,
    output logic                  c_ack,
    output logic [DATA_W-1:0]     c_rdata,
    output logic                  c_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DM_ADDRESS-1:0] d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [2:0]            d_funct3,
    output logic                  d_ack,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_a,
    output logic [DATA_W-1:0]     mem_wd,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rd,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    // r_owner/r_last: 0 = port C, 1 = port D
    logic                  r_owner;
    logic                  r_last;
    logic                  r_we;
    logic                  r_err;
    logic [DM_ADDRESS-1:0] r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_rdata;
    logic [2:0]            r_funct3;

    logic                  w_gnt_c;
    logic                  w_gnt_d;
    logic                  w_gnt;
    logic                  w_misal;
    logic [DM_ADDRESS-1:0] w_addr;
    logic [2:0]            w_f3;
    logic [DATA_W-1:0]     w_rdata;

    always_comb begin
        w_gnt_c = 1'b0;
        w_gnt_d = 1'b0;
        if (c_req && d_req) begin
            if (FIXED_PRIO != 0 || r_last)
                w_gnt_c = 1'b1;
            else
                w_gnt_d = 1'b1;
        end else begin
            w_gnt_c = c_req;
            w_gnt_d = d_req;
        end
    end

    assign w_gnt  = w_gnt_c | w_gnt_d;
    assign w_addr = w_gnt_d ? d_addr   : c_addr;
    assign w_f3   = w_gnt_d ? d_funct3 : c_funct3;

    always_comb begin
        w_misal = 1'b0;
        unique case (w_f3[1:0])
            2'b01:   w_misal = w_addr[0];
            2'b10:   w_misal = |w_addr[1:0];
            2'b11:   w_misal = 1'b1;
            default: w_misal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        c_ack     = 1'b0;
        d_ack     = 1'b0;
        c_err     = 1'b0;
        d_err     = 1'b0;
        c_rdata   = '0;
        d_rdata   = '0;
        busy      = (r_state != IDLE);
        unique case (r_state)
            IDLE: begin
                if (w_gnt)
                    w_next = w_misal ? DONE : ACCESS;
            end
            ACCESS: begin
                mem_read  = ~r_we;
                mem_write = r_we;
                w_next    = DONE;
            end
            DONE: begin
                if (r_owner) begin
                    d_ack   = 1'b1;
                    d_err   = r_err;
                    d_rdata = w_rdata;
                end else begin
                    c_ack   = 1'b1;
                    c_err   = r_err;
                    c_rdata = w_rdata;
                end
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_rdata = (!r_we && !r_err) ? r_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_funct3 <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_gnt) begin
                        r_owner  <= w_gnt_d;
                        r_we     <= w_gnt_d ? d_we : c_we;
                        r_addr   <= w_addr;
                        r_wdata  <= w_gnt_d ? d_wdata : c_wdata;
                        r_funct3 <= w_f3;
                        r_err    <= w_misal;
                        r_rdata  <= '0;
                    end
                end
                ACCESS: begin
                    if (!r_we)
                        r_rdata <= mem_rd;
                end
                DONE: r_last <= r_owner;
                default: ;
            endcase
        end
    end

    // Address/data/size hold the last latched request outside ACCESS
    assign mem_a      = r_addr;
    assign mem_wd     = r_wdata;
    assign mem_funct3 = r_funct3;

endmodule
